hdlc_tx_framer: RTL



---
 rtl/hdlc_pkg.sv | 20 ++
 rtl/hdlc_tx_framer_if.sv | 24 ++
 rtl/hdlc_stuff_counter.sv | 37 +++
 rtl/hdlc_tx_framer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
// Shared HDLC line definitions: FSM state codes, flag/abort patterns and
// the default stuffing run length. Used by both transmitter and receiver.
package hdlc_pkg;

    typedef logic [2:0] hdlc_state_t;

    localparam hdlc_state_t ST_IDLE  = 3'd0;
    localparam hdlc_state_t ST_OPEN  = 3'd1;
    localparam hdlc_state_t ST_DATA  = 3'd2;
    localparam hdlc_state_t ST_STUFF = 3'd3;
    localparam hdlc_state_t ST_CLOSE = 3'd4;
    localparam hdlc_state_t ST_ABORT = 3'd5;

    localparam logic [7:0] FLAG_PATTERN  = 8'h7E;
    // LSB first: one 0 then seven 1s.
    localparam logic [7:0] ABORT_PATTERN = 8'hFE;

    localparam int STUFF_RUN_DEF = 5;

endpackage

// File: rtl/hdlc_tx_framer_if.sv
// Byte-stream valid/ready handshake into the framer.
// Ports: in_valid, in_data[7:0] (LSB sent first), in_last, in_ready.
interface hdlc_tx_framer_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/hdlc_stuff_counter.sv
// Consecutive-ones counter for bit stuffing; saturates at STUFF_RUN.
// Ports: clk, reset, clr, shift_en, bit_in -> stuff_req (this bit completes a run).
import hdlc_pkg::*;

module hdlc_stuff_counter #(
    parameter int STUFF_RUN = STUFF_RUN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic shift_en,
    input  logic bit_in,
    output logic stuff_req
);

    localparam int W = $clog2(STUFF_RUN + 1);
    localparam logic [W-1:0] RUN    = W'(STUFF_RUN);
    localparam logic [W-1:0] RUN_M1 = W'(STUFF_RUN - 1);

    logic [W-1:0] cnt;

    // Combinational so the stuffed 0 can follow the completing 1 directly.
    assign stuff_req = shift_en & bit_in & (cnt == RUN_M1);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (shift_en) begin
            if (!bit_in) begin
                cnt <= '0;
            end else if (cnt != RUN) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC bit-serial transmitter: flags, zero-bit stuffing, abort on request/underrun.
// Ports: clk, reset, in_if (byte handshake), abort -> out_bit, out_frame, out_stuff, out_abort, err_underrun.
import hdlc_pkg::*;

module hdlc_tx_framer #(
    parameter bit IDLE_FLAGS = 1'b1,
    parameter int STUFF_RUN  = STUFF_RUN_DEF
) (
    input  logic               clk,
    input  logic               reset,
    hdlc_tx_framer_if.slave    in_if,
    input  logic               abort,
    output logic               out_bit,
    output logic               out_frame,
    output logic               out_stuff,
    output logic               out_abort,
    output logic               err_underrun
);

    hdlc_state_t st, n_st;
    logic [2:0]  idx, n_idx;
    logic [7:0]  shreg;
    logic        sh_last;
    logic [7:0]  hold_data;
    logic        hold_last;
    logic        hold_valid;
    logic        bdone, n_bdone;
    logic        upend, n_upend;

    logic n_bit, n_frame, n_stuff, n_abort, n_err;
    logic load, flush, xfer;
    logic data_en, stuff_req, byte_end, abort_hit;

    assign in_if.in_ready = ~hold_valid;
    assign xfer = in_if.in_valid & ~hold_valid;

    // A data bit goes onto the line only in DATA without an abort override.
    assign data_en = (st == ST_DATA) & ~abort;

    hdlc_stuff_counter #(
        .STUFF_RUN (STUFF_RUN)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (~data_en),
        .shift_en  (data_en),
        .bit_in    (shreg[idx]),
        .stuff_req (stuff_req)
    );

    assign abort_hit = abort & ((st == ST_DATA) | (st == ST_STUFF));

    // Byte finished with no stuff bit still owed.
    assign byte_end = ~abort &
        (((st == ST_DATA) & ~stuff_req & (idx == 3'd7)) |
         ((st == ST_STUFF) & bdone));

    always_comb begin
        n_st    = st;
        n_idx   = idx + 3'd1;
        n_bit   = 1'b1;
        n_frame = 1'b0;
        n_stuff = 1'b0;
        n_abort = 1'b0;
        n_err   = 1'b0;
        n_bdone = 1'b0;
        n_upend = 1'b0;
        load    = 1'b0;
        flush   = 1'b0;
        unique case (st)
            ST_IDLE: begin
                n_bit = IDLE_FLAGS ? FLAG_PATTERN[idx] : 1'b1;
                if (idx == 3'd7 && hold_valid) n_st = ST_OPEN;
            end
            ST_OPEN: begin
                n_bit   = FLAG_PATTERN[idx];
                n_frame = 1'b1;
                if (idx == 3'd7) begin
                    n_st = ST_DATA;
                    load = 1'b1;
                end
            end
            ST_DATA: begin
                n_bit   = shreg[idx];
                n_frame = 1'b1;
                if (stuff_req) begin
                    n_st    = ST_STUFF;
                    n_bdone = (idx == 3'd7);
                end
            end
            ST_STUFF: begin
                n_bit   = 1'b0;
                n_frame = 1'b1;
                n_stuff = 1'b1;
                // Stuff bit is not part of the byte: hold the index.
                n_idx   = idx;
                if (!bdone) n_st = ST_DATA;
            end
            ST_CLOSE: begin
                n_bit   = FLAG_PATTERN[idx];
                n_frame = 1'b1;
                if (idx == 3'd7) begin
                    if (hold_valid) begin
                        n_st = ST_DATA;
                        load = 1'b1;
                    end else begin
                        n_st = ST_IDLE;
                    end
                end
            end
            ST_ABORT: begin
                n_bit = ABORT_PATTERN[idx];
                n_err = upend & (idx == 3'd0);
                if (idx == 3'd7) begin
                    n_abort = 1'b1;
                    n_st    = ST_IDLE;
                end
            end
            default: begin
                n_st  = ST_IDLE;
                n_idx = 3'd0;
            end
        endcase

        if (byte_end) begin
            if (sh_last) begin
                n_st = ST_CLOSE;
            end else if (hold_valid) begin
                n_st = ST_DATA;
                load = 1'b1;
            end else begin
                n_st    = ST_ABORT;
                n_upend = 1'b1;
                flush   = 1'b1;
            end
        end

        // Requested abort replaces this cycle's bit with the first abort bit.
        if (abort_hit) begin
            n_bit   = ABORT_PATTERN[0];
            n_frame = 1'b0;
            n_stuff = 1'b0;
            n_st    = ST_ABORT;
            n_idx   = 3'd1;
            n_bdone = 1'b0;
            n_upend = 1'b0;
            load    = 1'b0;
            flush   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= ST_IDLE;
            idx          <= 3'd0;
            shreg        <= 8'd0;
            sh_last      <= 1'b0;
            hold_data    <= 8'd0;
            hold_last    <= 1'b0;
            hold_valid   <= 1'b0;
            bdone        <= 1'b0;
            upend        <= 1'b0;
            out_bit      <= 1'b1;
            out_frame    <= 1'b0;
            out_stuff    <= 1'b0;
            out_abort    <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            st           <= n_st;
            idx          <= n_idx;
            bdone        <= n_bdone;
            upend        <= n_upend;
            out_bit      <= n_bit;
            out_frame    <= n_frame;
            out_stuff    <= n_stuff;
            out_abort    <= n_abort;
            err_underrun <= n_err;
            if (load) begin
                shreg   <= hold_data;
                sh_last <= hold_last;
            end else if (flush) begin
                shreg   <= 8'd0;
                sh_last <= 1'b0;
            end
            if (flush || load) begin
                hold_valid <= 1'b0;
            end else if (xfer) begin
                hold_valid <= 1'b1;
                hold_data  <= in_if.in_data;
                hold_last  <= in_if.in_last;
            end
        end
    end

endmodule
